// File: rtl/alu_instr_sequencer_if.sv
// rtl/alu_instr_sequencer_if.sv - upstream instruction handshake bundle for alu_instr_sequencer
`timescale 1ns/1ps
interface alu_instr_sequencer_if #(
    parameter int IW = 23
);
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - instruction FIFO and issue stage ahead of bit8ALU; SEQ_HAZARD_STALL_EN enables RAW bubble
`timescale 1ns/1ps
module alu_instr_sequencer #(
    parameter int DEPTH = 4,
    parameter int IW    = 23
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    alu_instr_sequencer_if.slave     up,
    input  logic                     halt,
    input  logic                     flush,
    output logic [3:0]               addr1,
    output logic [3:0]               addr2,
    output logic [3:0]               rd,
    output logic [2:0]               func,
    output logic [7:0]               memaddr,
    output logic                     write,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              issued_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ready_en;
    logic [IW-1:0] head;
    logic          hazard;
    logic          push;
    logic          pop;

    // ready_en keeps in_ready low through reset and for the release edge itself
    assign up.in_ready = ready_en && (count < FULL);
    assign head        = mem[rd_ptr];

`ifdef SEQ_HAZARD_STALL_EN
    assign hazard = write && ((head[15:12] == rd) || (head[11:8] == rd));
`else
    assign hazard = 1'b0;
`endif

    assign push = up.in_valid && up.in_ready && !flush;
    assign pop  = !flush && !halt && (count != '0) && !hazard;

    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr] <= up.in_instr;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            addr1      <= '0;
            addr2      <= '0;
            rd         <= '0;
            func       <= '0;
            memaddr    <= '0;
            write      <= 1'b0;
            issued_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                write  <= 1'b0;
            end else begin
                write <= pop;
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr     <= rd_ptr + PW'(1);
                    func       <= head[22:20];
                    rd         <= head[19:16];
                    addr1      <= head[15:12];
                    addr2      <= head[11:8];
                    memaddr    <= head[7:0];
                    issued_cnt <= issued_cnt + 16'd1;
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - directed self-checking bench for alu_instr_sequencer
`timescale 1ns/1ps
module tb_alu_instr_sequencer;

    logic        clk1;
    logic        rst_n;
    logic        halt;
    logic        flush;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic [3:0]  rd;
    logic [2:0]  func;
    logic [7:0]  memaddr;
    logic        write;
    logic [2:0]  count;
    logic [15:0] issued_cnt;

    int vectors     = 0;
    int miscompares = 0;

    alu_instr_sequencer_if #(.IW(23)) bus ();

    alu_instr_sequencer #(.DEPTH(4), .IW(23)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .up         (bus),
        .halt       (halt),
        .flush      (flush),
        .addr1      (addr1),
        .addr2      (addr2),
        .rd         (rd),
        .func       (func),
        .memaddr    (memaddr),
        .write      (write),
        .count      (count),
        .issued_cnt (issued_cnt)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    function automatic logic [22:0] mk(input logic [2:0] f, input logic [3:0] d,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [7:0] m);
        return {f, d, a, b, m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk1);
    endtask

    initial begin
        rst_n        = 1'b0;
        halt         = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd7, 4'd9, 4'd9, 4'd9, 8'hff);

        // Reset held with in_valid asserted
        tick(); tick();
        chk("rst_write",   write, 0);
        chk("rst_addr1",   addr1, 0);
        chk("rst_addr2",   addr2, 0);
        chk("rst_rd",      rd, 0);
        chk("rst_func",    func, 0);
        chk("rst_memaddr", memaddr, 0);
        chk("rst_count",   count, 0);
        chk("rst_issued",  issued_cnt, 0);
        chk("rst_ready",   bus.in_ready, 0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        chk("rel_ready", bus.in_ready, 1);
        chk("rel_count", count, 0);

        // Basic issue
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd0, 4'd10, 4'd3, 4'd5, 8'd225);
        tick();
        bus.in_valid = 1'b0;
        chk("b_count1", count, 1);
        chk("b_nobypass", write, 0);
        tick();
        chk("b_func",    func, 0);
        chk("b_rd",      rd, 10);
        chk("b_addr1",   addr1, 3);
        chk("b_addr2",   addr2, 5);
        chk("b_memaddr", memaddr, 225);
        chk("b_write",   write, 1);
        chk("b_issued",  issued_cnt, 1);
        tick();
        chk("b_write_drop", write, 0);
        chk("b_rd_hold",    rd, 10);

        // Full / backpressure under halt
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = mk(3'(i + 1), 4'(i), 4'(i + 2), 4'(i + 3), 8'(8'h10 + i));
            chk("f_ready_pre", bus.in_ready, (i < 4) ? 1 : 0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("f_count", count, 4);
        chk("f_ready", bus.in_ready, 0);
        chk("f_halt_nowrite", write, 0);
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("f_issue_write", write, 1);
            chk("f_issue_mem",   memaddr, 8'h10 + i);
            chk("f_issue_func",  func, i + 1);
        end
        tick();
        chk("f_drain_write", write, 0);
        chk("f_drain_count", count, 0);
        chk("f_issued",      issued_cnt, 5);

        // RAW hazard: ADD rd=10 then XOR addr1=10
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd0, 4'd10, 4'd1, 4'd2, 8'h40);
        tick();
        bus.in_instr = mk(3'd4, 4'd11, 4'd10, 4'd4, 8'h41);
        tick();
        bus.in_valid = 1'b0;
        chk("h_add_write", write, 1);
        chk("h_add_mem",   memaddr, 8'h40);
        tick();
`ifdef SEQ_HAZARD_STALL_EN
        chk("h_bubble", write, 0);
        tick();
`endif
        chk("h_xor_write", write, 1);
        chk("h_xor_mem",   memaddr, 8'h41);
        tick();
        chk("h_idle",   write, 0);
        chk("h_issued", issued_cnt, 7);

        // Flush with a concurrent push
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = mk(3'd1, 4'd2, 4'd3, 4'd4, 8'(8'h50 + i));
            tick();
        end
        chk("fl_count_pre", count, 3);
        flush        = 1'b1;
        bus.in_instr = mk(3'd1, 4'd2, 4'd3, 4'd4, 8'h5f);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        halt         = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_write", write, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_noissue", write, 0);
        end
        chk("fl_issued", issued_cnt, 7);
        chk("fl_mem_hold", memaddr, 8'h41);

        // Pointer wrap: 2*DEPTH streamed instructions
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = mk(3'd5, 4'(i), 4'd15, 4'd15, 8'(8'h80 + i));
            tick();
            if (i > 0) begin
                chk("w_write", write, 1);
                chk("w_mem",   memaddr, 8'h80 + i - 1);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        chk("w_last_write", write, 1);
        chk("w_last_mem",   memaddr, 8'h87);
        chk("w_issued",     issued_cnt, 15);

        // issued_cnt wrap: stream up to 65535, then one more
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd6, 4'd0, 4'd15, 4'd15, 8'h01);
        for (int i = 0; i < 65520; i++) tick();
        bus.in_valid = 1'b0;
        tick();
        chk("c_max", issued_cnt, 16'hffff);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("c_wrap",  issued_cnt, 0);
        chk("c_write", write, 1);

        // Asynchronous reset mid-stream discards buffered entries
        halt = 1'b1;
        bus.in_valid = 1'b1;
        tick(); tick();
        bus.in_valid = 1'b0;
        chk("r_count_pre", count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("r_count", count, 0);
        chk("r_write", write, 0);
        chk("r_ready", bus.in_ready, 0);
        chk("r_issued", issued_cnt, 0);
        tick();
        rst_n = 1'b1;
        halt  = 1'b0;
        tick(); tick();
        chk("r_noissue", write, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Instruction buffer and issue stage directly upstream of `bit8ALU`. Accepts packed ALU instructions over a valid/ready handshake, holds them in a small FIFO, and drives the ALU operand, destination, function, memory-address and write fields one instruction per cycle. Optionally inserts a one-cycle bubble on a read-after-write hazard against the previously issued destination register.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `IW`, 23: instruction width; fixed format `{func[22:20], rd[19:16], addr1[15:12], addr2[11:8], memaddr[7:0]}`.
- `clk1`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream instruction present.
- `in_instr`  in  IW  packed instruction.
- `in_ready`  out  1  FIFO can accept; push = `in_valid & in_ready`.
- `halt`  in  1  freeze issue; FIFO still accepts pushes.
- `flush`  in  1  synchronous discard of all buffered instructions.
- `addr1`, `addr2`, `rd`  out  4 each  ALU register-bank indices.
- `func`  out  3  ALU operation (0 ADD … 7 INC A).
- `memaddr`  out  8  ALU result memory address.
- `write`  out  1  issue strobe / ALU write enable; 1 for exactly one cycle per issued instruction.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `issued_cnt`  out  16  total instructions issued; wraps at 65535 → 0.

## Operation
- Decided: one clock (`clk1`); reset is asynchronous and active-low (`rst_n`).
- Reset: `addr1`, `addr2`, `rd`, `func`, `memaddr`, `write` = 0; `count` = 0; `issued_cnt` = 0; pointers = 0; `in_ready` = 0 while `rst_n` is low, 1 from the first cycle after release.
- `in_ready` = `(count < DEPTH)` from registered state only. A full FIFO refuses a push even when a pop happens in the same cycle.
- Issue condition per cycle: `!flush & !halt & count>0 & !hazard`. On issue: head fields are registered onto the outputs, `write`=1, head is popped, and `issued_cnt` is incremented.
- No issue: `write`=0; `addr1`/`addr2`/`rd`/`func`/`memaddr` hold their last values.
- Hazard (macro-gated): `write` currently 1 and (head.addr1 == `rd` or head.addr2 == `rd`). Hazard forces exactly one bubble. The next cycle has `write`=0, so the hazard clears.
- Simultaneous push and pop: `count` is unchanged and both pointers advance; wrap modulo DEPTH.
- Push into an empty FIFO: the entry is not issuable in the same cycle. No bypass path exists.
- `flush`: priority over push, pop and `halt`. On the next edge `count`=0, pointers are reset, and `write`=0. A push in the flush cycle is dropped. `issued_cnt` is unaffected.
- `halt` while `write`=1: the next edge drops `write` to 0. No instruction is lost.
- Reset mid-stream: all buffered instructions are discarded immediately (asynchronous).

## Timing
- Minimum latency: instruction pushed at edge k appears on the outputs with `write`=1 after edge k+1.
- Throughput: 1 instruction/cycle without hazards. A hazard pair costs 2 cycles.
- All ALU-facing outputs are registered. `in_ready` is combinational from `count`.
- `count` reflects pushes and pops of edge k after edge k.

## Configuration
- `SEQ_HAZARD_STALL_EN` defined: hazard detection and a one-cycle bubble, as above.
- `SEQ_HAZARD_STALL_EN` undefined: the hazard term is constant 0, and dependent instructions issue back-to-back. Software must then space dependent instructions.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1.
  - All outputs must be 0 and `in_ready`=0.
  - After release, `in_ready`=1 and `count`=0.
- Basic issue: push `{0,10,3,5,225}` at edge 1.
  - After edge 2: `func`=0, `rd`=10, `addr1`=3, `addr2`=5, `memaddr`=225, `write`=1, `issued_cnt`=1.
  - After edge 3: `write`=0.
- Full/backpressure: with `halt`=1, push 5 instructions into DEPTH=4.
  - `in_ready`=0 after 4 pushes, `count`=4, and the 5th is not accepted.
  - Release `halt`: 4 issues on consecutive cycles in FIFO order.
- Hazard with macro: push ADD rd=10, then XOR addr1=10.
  - `write` sequence is 1,0,1 and the XOR issues 2 cycles after the ADD.
  - Without the macro the sequence is 1,1.
- Flush: buffer 3 instructions, assert `flush` for one cycle together with a push.
  - Next cycle: `count`=0 and `write`=0.
  - No further issues; `issued_cnt` unchanged.
- Wrap: issue 65536 instructions.
  - `issued_cnt` returns to 0.
  - Pointer wrap is checked by pushing 2×DEPTH instructions with in-order issue.
